fetch_ctrl: RTL and testbench

Sequencer between the PC register and a variable-latency instruction memory, replacing the free-running PC update of the single-cycle fetch stage. Issues one fetch request at a time, holds the address stable until acknowledged, buffers the returned instruction until decode accepts it, and applies branch/jump redirects from execute. This includes squashing a fetch already in flight when a redirect arrives.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_next_pc.sv | 31 +++
 rtl/fetch_ctrl.sv | 107 ++++++++++
 tb/tb_fetch_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer.
// Provides the FSM state type plus the default reset PC and sequential increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

  localparam int unsigned PcInc   = 4;
  localparam logic [31:0] StartPc = 32'h0000_0040;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the fetch sequencer.
// Ports:
//   pc_i          current PC
//   inc_i         advance PC by PC_INC (ignored when redirect_i is set)
//   redirect_i    take the redirect target
//   redirect_pc_i redirect target; the low two bits are cleared
//   next_pc_o     selected next PC
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned DBITS  = 32,
  parameter int unsigned PC_INC = PcInc
) (
  input  logic [DBITS-1:0] pc_i,
  input  logic             inc_i,
  input  logic             redirect_i,
  input  logic [DBITS-1:0] redirect_pc_i,
  output logic [DBITS-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i;
    if (redirect_i) begin
      next_pc_o = {redirect_pc_i[DBITS-1:2], 2'b00};
    end else if (inc_i) begin
      // Wraps modulo 2^DBITS.
      next_pc_o = pc_i + DBITS'(PC_INC);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer between the PC and a variable-latency instruction memory.
// One request at a time; address held until ack; the returned word is buffered
// until decode accepts it; redirects from execute squash buffered or in-flight work.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   imemReq/imemAddr           request to instruction memory
//   imemAck/imemData           memory response
//   redirect/redirectPc        redirect from execute
//   instrValid/instr/instrPc   buffered instruction for decode
//   instrReady                 decode accepts the buffered instruction
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned      DBITS    = 32,
  parameter logic [DBITS-1:0] START_PC = DBITS'(StartPc),
  parameter int unsigned      PC_INC   = PcInc
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imemReq,
  output logic [DBITS-1:0] imemAddr,
  input  logic             imemAck,
  input  logic [31:0]      imemData,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirectPc,
  output logic             instrValid,
  output logic [31:0]      instr,
  output logic [DBITS-1:0] instrPc,
  input  logic             instrReady
);

  fetch_state_e     state_q, state_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic [DBITS-1:0] drain_addr_q, drain_addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [DBITS-1:0] instr_pc_q, instr_pc_d;
  logic             pc_inc;

  fetch_next_pc #(
    .DBITS (DBITS),
    .PC_INC(PC_INC)
  ) u_next_pc (
    .pc_i         (pc_q),
    .inc_i        (pc_inc),
    .redirect_i   (redirect),
    .redirect_pc_i(redirectPc),
    .next_pc_o    (pc_d)
  );

  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    pc_inc       = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (redirect) begin
          // Without an ack the request is still outstanding and must be drained
          // at its original address before the redirect target is requested.
          if (!imemAck) begin
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end
        end else if (imemAck) begin
          instr_d    = imemData;
          instr_pc_d = pc_q;
          pc_inc     = 1'b1;
          state_d    = StHold;
        end
      end
      StDrain: begin
        if (imemAck) state_d = StFetch;
      end
      StHold: begin
        if (redirect || instrReady) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= START_PC;
      drain_addr_q <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  always_comb begin
    imemReq    = (state_q == StFetch) || (state_q == StDrain);
    imemAddr   = (state_q == StDrain) ? drain_addr_q : pc_q;
    instrValid = (state_q == StHold);
    instr      = instr_q;
    instrPc    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, imemReq, imemAck, redirect, instrValid, instrReady;
  logic [31:0] imemAddr, imemData, redirectPc, instr, instrPc;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemAck   (imemAck),
    .imemData  (imemData),
    .redirect  (redirect),
    .redirectPc(redirectPc),
    .instrValid(instrValid),
    .instr     (instr),
    .instrPc   (instrPc),
    .instrReady(instrReady)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level reference: a startup bubble, an optional buffered word,
  // an optional squashed request still owed an ack, and the next fetch PC.
  bit          m_idle, m_buf, m_stale;
  logic [31:0] m_pc, m_stale_addr, m_instr, m_ipc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] rd;
    rd = {redirectPc[31:2], 2'b00};
    if (reset) begin
      m_idle = 1; m_buf = 0; m_stale = 0;
      m_pc = 32'h40; m_instr = 0; m_ipc = 0;
    end else if (m_idle) begin
      m_idle = 0;
      if (redirect) m_pc = rd;
    end else if (m_buf) begin
      if (redirect) begin m_buf = 0; m_pc = rd; end
      else if (instrReady) m_buf = 0;
    end else if (m_stale) begin
      if (imemAck) m_stale = 0;
      if (redirect) m_pc = rd;
    end else if (redirect) begin
      if (!imemAck) begin m_stale = 1; m_stale_addr = m_pc; end
      m_pc = rd;
    end else if (imemAck) begin
      m_buf = 1; m_instr = imemData; m_ipc = m_pc; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all();
    chk("imemReq", {31'b0, imemReq}, {31'b0, !m_idle && !m_buf});
    chk("imemAddr", imemAddr, m_stale ? m_stale_addr : m_pc);
    chk("instrValid", {31'b0, instrValid}, {31'b0, m_buf});
    chk("instr", instr, m_instr);
    chk("instrPc", instrPc, m_ipc);
  endtask

  // Drive inputs for one cycle, advance, then check #1 after the edge.
  task automatic cyc(input logic rst, input logic ack, input logic [31:0] data,
                     input logic rdr, input logic [31:0] rpc, input logic rdy);
    reset = rst; imemAck = ack; imemData = data;
    redirect = rdr; redirectPc = rpc; instrReady = rdy;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1; imemAck = 0; imemData = 0; redirect = 0; redirectPc = 0; instrReady = 0;

    // Reset and first fetch.
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_addr", imemAddr, 32'h40);
    cyc(0, 0, 0, 0, 0, 1);
    chk("first_req_addr", imemAddr, 32'h40);
    cyc(0, 1, 32'h1234, 0, 0, 1);
    chk("first_instr", instr, 32'h1234);
    cyc(0, 0, 0, 0, 0, 1);
    chk("next_addr", imemAddr, 32'h44);

    // Delayed ack: three waiting cycles, then ack and handoff.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("delay_addr", imemAddr, 32'h44);
    cyc(0, 1, 32'hAAAA_0001, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Redirect with a request outstanding: drain, discard, refetch at 0x100.
    cyc(0, 0, 0, 1, 32'h103, 0);
    chk("drain_addr", imemAddr, 32'h48);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("post_drain_addr", imemAddr, 32'h100);
    chk("drain_no_valid", {31'b0, instrValid}, 32'h0);

    // Hold with decode stalled, then redirect drops the buffered word.
    cyc(0, 1, 32'h5555_AAAA, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("hold_instr", instr, 32'h5555_AAAA);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("redir_addr", imemAddr, 32'hFFFF_FFFC);

    // PC wrap.
    cyc(0, 1, 32'h0BAD_F00D, 0, 0, 1);
    chk("wrap_ipc", instrPc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_addr", imemAddr, 32'h0);

    // Reset mid-drain.
    cyc(0, 0, 0, 1, 32'h300, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_drain_req", {31'b0, imemReq}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("restart_addr", imemAddr, 32'h40);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, $urandom,
          $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
